// File: rtl/mrav_bus_arbiter.sv
// Round-robin arbiter sharing the mrav decoder's single core-side port between N requesters.
// Optional per-transaction watchdog is enabled with `define MRAV_ARB_TIMEOUT_EN.
module mrav_bus_arbiter #(
  parameter int N_MASTERS       = 2,
  parameter int TIMEOUT_CYCLES  = 255,
  parameter int MRAV_ADDR_WIDTH = 32,
  parameter int MRAV_DATA_WIDTH = 32
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [N_MASTERS-1:0]                 m_read,
  input  logic [N_MASTERS-1:0]                 m_write,
  input  logic [N_MASTERS*MRAV_ADDR_WIDTH-1:0] m_addr,
  input  logic [N_MASTERS*MRAV_DATA_WIDTH-1:0] m_data_out,
  output logic [MRAV_DATA_WIDTH-1:0]           m_data_in,
  output logic [N_MASTERS-1:0]                 m_read_done,
  output logic [N_MASTERS-1:0]                 m_write_done,
  output logic [N_MASTERS-1:0]                 m_error,
  output logic                                 core_read,
  output logic                                 core_write,
  output logic [MRAV_ADDR_WIDTH-1:0]           mrav_addr,
  output logic [MRAV_DATA_WIDTH-1:0]           mrav_data_out,
  input  logic [MRAV_DATA_WIDTH-1:0]           mrav_data_in,
  input  logic                                 mrav_read_done,
  input  logic                                 mrav_write_done,
  output logic [N_MASTERS-1:0]                 grant,
  output logic                                 busy
);

  localparam int IDX_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

  if (N_MASTERS < 2 || N_MASTERS > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("mrav_bus_arbiter: N_MASTERS must be 2..8 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t               state;
  logic [IDX_W-1:0]     gidx;
  logic [IDX_W-1:0]     last_grant;
  logic [N_MASTERS-1:0] req;
  logic [IDX_W-1:0]     pick;

  logic in_busy;
  logic g_read;
  logic g_write;
  logic g_req;
  logic raw_read;
  logic raw_write;
  logic done_raw;
  logic abort;
  logic timeout_hit;
  logic txn_end;

  // Scan last+1, last+2, ... and keep the closest requester; last itself has lowest priority.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [IDX_W-1:0] last,
                                               input logic [N_MASTERS-1:0] r);
    int                   idx;
    logic [N_MASTERS-1:0] sh;
    rr_pick = last;
    for (int k = N_MASTERS; k >= 1; k--) begin
      idx = int'(last) + k;
      if (idx >= N_MASTERS) idx = idx - N_MASTERS;
      sh = r >> idx;
      if (sh[0]) rr_pick = IDX_W'(idx);
    end
  endfunction

  assign req  = m_read | m_write;
  assign pick = rr_pick(last_grant, req);

  assign in_busy = (state == S_BUSY);
  assign busy    = in_busy;

  assign g_read  = m_read[gidx];
  assign g_write = m_write[gidx];
  assign g_req   = req[gidx];

  // Read wins when a master illegally raises both strobes.
  assign raw_read  = in_busy & g_read;
  assign raw_write = in_busy & g_write & ~g_read;

  assign done_raw = (mrav_read_done & raw_read) | (mrav_write_done & raw_write);
  assign abort    = in_busy & ~g_req;

`ifdef MRAV_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] busy_cnt;

  // busy_cnt is 0 in the first BUSY cycle, so the abort lands on BUSY cycle TIMEOUT_CYCLES.
  always_ff @(posedge clk) begin
    if (!rst_n || state == S_IDLE) begin
      busy_cnt <= '0;
    end else begin
      busy_cnt <= busy_cnt + CNT_W'(1);
    end
  end

  assign timeout_hit = in_busy & g_req & ~done_raw &
                       (busy_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  assign txn_end = done_raw | abort | timeout_hit;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      grant      <= '0;
      gidx       <= '0;
      last_grant <= IDX_W'(N_MASTERS - 1);
    end else begin
      case (state)
        S_IDLE: begin
          if (|req) begin
            state <= S_BUSY;
            gidx  <= pick;
            grant <= N_MASTERS'(1) << pick;
          end
        end
        S_BUSY: begin
          if (txn_end) begin
            state      <= S_IDLE;
            grant      <= '0;
            last_grant <= gidx;
          end
        end
        default: begin
          state <= S_IDLE;
          grant <= '0;
        end
      endcase
    end
  end

  assign core_read  = raw_read & ~timeout_hit;
  assign core_write = raw_write & ~timeout_hit;

  assign mrav_addr     = in_busy ? m_addr[int'(gidx)*MRAV_ADDR_WIDTH +: MRAV_ADDR_WIDTH]
                                 : '0;
  assign mrav_data_out = in_busy ? m_data_out[int'(gidx)*MRAV_DATA_WIDTH +: MRAV_DATA_WIDTH]
                                 : '0;
  assign m_data_in     = (in_busy & ~timeout_hit) ? mrav_data_in : '0;

  // grant is one-hot on the owner while BUSY and zero in IDLE, so it doubles as the return-path mask.
  assign m_read_done  = {N_MASTERS{mrav_read_done & core_read}} & grant;
  assign m_write_done = {N_MASTERS{mrav_write_done & core_write}} & grant;
  assign m_error      = {N_MASTERS{timeout_hit}} & grant;

endmodule

// File: tb/tb_mrav_bus_arbiter.sv
// Self-checking bench for mrav_bus_arbiter: directed scenarios plus randomized traffic
// compared cycle by cycle against a transaction-level round-robin model.
module tb_mrav_bus_arbiter;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    m_read, m_write;
  logic [N*AW-1:0] m_addr;
  logic [N*DW-1:0] m_data_out;
  logic [DW-1:0]   m_data_in;
  logic [N-1:0]    m_read_done, m_write_done, m_error;
  logic            core_read, core_write;
  logic [AW-1:0]   mrav_addr;
  logic [DW-1:0]   mrav_data_out;
  logic [DW-1:0]   mrav_data_in;
  logic            mrav_read_done, mrav_write_done;
  logic [N-1:0]    grant;
  logic            busy;

  mrav_bus_arbiter #(
    .N_MASTERS(N), .TIMEOUT_CYCLES(TO), .MRAV_ADDR_WIDTH(AW), .MRAV_DATA_WIDTH(DW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m_read(m_read), .m_write(m_write), .m_addr(m_addr), .m_data_out(m_data_out),
    .m_data_in(m_data_in), .m_read_done(m_read_done), .m_write_done(m_write_done),
    .m_error(m_error), .core_read(core_read), .core_write(core_write),
    .mrav_addr(mrav_addr), .mrav_data_out(mrav_data_out), .mrav_data_in(mrav_data_in),
    .mrav_read_done(mrav_read_done), .mrav_write_done(mrav_write_done),
    .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: who owns the bus, who owned it last, and how many BUSY cycles so far.
  bit           mbusy;
  int           mg, mlast, mcyc;
  logic [N-1:0] fin;

  // One clock cycle: check outputs against the model at negedge+1, then advance the model.
  task automatic step();
    logic [N-1:0]  req, e_grant, e_rdd, e_wrd, e_err;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_dout, e_din;
    bit            rd, wr, reqg, dn, to, e_cr, e_cw;
    #1;
    req = m_read | m_write;
    e_grant = '0; e_rdd = '0; e_wrd = '0; e_err = '0;
    e_addr = '0; e_dout = '0; e_din = '0;
    rd = 0; wr = 0; reqg = 0; dn = 0; to = 0; e_cr = 0; e_cw = 0;
    if (mbusy) begin
      rd   = m_read[mg];
      wr   = m_write[mg] && !rd;
      reqg = req[mg];
      dn   = (rd && mrav_read_done) || (wr && mrav_write_done);
`ifdef MRAV_ARB_TIMEOUT_EN
      to   = reqg && !dn && (mcyc == TO);
`endif
      e_grant[mg] = 1'b1;
      e_cr        = rd && !to;
      e_cw        = wr && !to;
      e_addr      = m_addr[mg*AW +: AW];
      e_dout      = m_data_out[mg*DW +: DW];
      e_din       = to ? '0 : mrav_data_in;
      e_rdd[mg]   = rd && mrav_read_done;
      e_wrd[mg]   = wr && mrav_write_done;
      e_err[mg]   = to;
    end
    check("grant", grant, e_grant);
    check("busy", busy, mbusy);
    check("core_read", core_read, e_cr);
    check("core_write", core_write, e_cw);
    check("mrav_addr", mrav_addr, e_addr);
    check("mrav_data_out", mrav_data_out, e_dout);
    check("m_data_in", m_data_in, e_din);
    check("m_read_done", m_read_done, e_rdd);
    check("m_write_done", m_write_done, e_wrd);
    check("m_error", m_error, e_err);
    fin = e_rdd | e_wrd | e_err;
    @(posedge clk);
    if (!rst_n) begin
      mbusy = 0;
      mlast = N - 1;
    end else if (!mbusy) begin
      if (|req) begin
        for (int k = N; k >= 1; k--)
          if (req[(mlast + k) % N]) mg = (mlast + k) % N;
        mbusy = 1;
        mcyc  = 1;
      end
    end else if (dn || !reqg || to) begin
      mbusy = 0;
      mlast = mg;
    end else begin
      mcyc++;
    end
    @(negedge clk);
  endtask

  // Masters hold a request until completion, occasionally abort; decoder answers at random.
  task automatic drive_random();
    int sel;
    for (int i = 0; i < N; i++) begin
      if (fin[i]) begin
        m_read[i] = 1'b0; m_write[i] = 1'b0;
      end else if (!(m_read[i] | m_write[i])) begin
        if ($urandom_range(3) == 0) begin
          sel = $urandom_range(15);
          m_read[i]  = (sel <= 7);
          m_write[i] = (sel == 0) || (sel > 7);
          m_addr[i*AW +: AW]     = $urandom;
          m_data_out[i*DW +: DW] = $urandom;
        end
      end else if ($urandom_range(39) == 0) begin
        m_read[i] = 1'b0; m_write[i] = 1'b0;
      end
    end
    mrav_read_done  = ($urandom_range(2) == 0);
    mrav_write_done = ($urandom_range(2) == 0);
    mrav_data_in    = $urandom;
    rst_n           = ($urandom_range(499) != 0);
  endtask

  initial begin
    rst_n = 1'b0; m_read = '0; m_write = '0; m_addr = '0; m_data_out = '0;
    mrav_data_in = '0; mrav_read_done = 1'b0; mrav_write_done = 1'b0;
    mbusy = 0; mlast = N - 1; mg = 0; mcyc = 0; fin = '0;
    @(negedge clk);
    step(); step();
    rst_n = 1'b1;
    #1 check("rst_grant", grant, 0); check("rst_busy", busy, 0);
    step();

    // Single read, done on the third BUSY cycle.
    m_read = 3'b001; m_addr[0 +: AW] = 32'h100;
    step();
    #1 check("sr_grant", grant, 3'b001); check("sr_addr", mrav_addr, 32'h100);
    step(); step();
    mrav_read_done = 1'b1; mrav_data_in = 32'hDEADBEEF;
    #1 check("sr_done", m_read_done, 3'b001); check("sr_data", m_data_in, 32'hDEADBEEF);
    step();
    m_read = '0; mrav_read_done = 1'b0;
    #1 check("sr_release", grant, 0);
    step();

    // Contention from reset with a zero-wait peripheral.
    rst_n = 1'b0; step(); rst_n = 1'b1;
    m_read = 3'b011; mrav_read_done = 1'b1;
    for (int t = 0; t < 8; t++) begin
      #1;
      if (t % 2 == 1) begin
        check("cont_grant", grant, (t % 4 == 1) ? 3'b001 : 3'b010);
        check("cont_done", m_read_done, (t % 4 == 1) ? 3'b001 : 3'b010);
      end else begin
        check("cont_gap", core_read, 0);
      end
      step();
    end
    m_read = '0; mrav_read_done = 1'b0;
    step(); step();

    // Write routing from master 1.
    m_write = 3'b010; m_addr[AW +: AW] = 32'h200; m_data_out[DW +: DW] = 32'h5A5A;
    step();
    #1 check("wr_addr", mrav_addr, 32'h200); check("wr_data", mrav_data_out, 32'h5A5A);
    check("wr_core_write", core_write, 1); check("wr_core_read", core_read, 0);
    mrav_write_done = 1'b1;
    #1 check("wr_done", m_write_done, 3'b010);
    step();
    m_write = '0; mrav_write_done = 1'b0;
    step();

    // Abort by master 0 with master 1 pending.
    m_read = 3'b011;
    step();
    #1 check("ab_grant", grant, 3'b001);
    step(); step();
    m_read = 3'b010; mrav_read_done = 1'b1;
    #1 check("ab_no_done", m_read_done, 0);
    step();
    #1 check("ab_idle_busy", busy, 0); check("ab_idle_grant", grant, 0);
    step();
    #1 check("ab_next", grant, 3'b010); check("ab_next_done", m_read_done, 3'b010);
    step();
    m_read = '0; mrav_read_done = 1'b0;
    step();

    // Reset while master 1 owns the bus; master 0 must win afterwards.
    m_read = 3'b001; mrav_read_done = 1'b1;
    step(); step();
    m_read = '0; mrav_read_done = 1'b0;
    step();
    m_read = 3'b010;
    step(); step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; m_read = 3'b011;
    #1 check("mr_core_read", core_read, 0); check("mr_grant", grant, 0); check("mr_busy", busy, 0);
    step();
    #1 check("mr_prio", grant, 3'b001);
    step();
    m_read = '0;
    step(); step();

`ifdef MRAV_ARB_TIMEOUT_EN
    // Decoder never answers: error pulse on BUSY cycle TO.
    m_read = 3'b001;
    step();
    for (int k = 1; k <= TO; k++) begin
      #1;
      if (k == TO) begin
        check("to_error", m_error, 3'b001);
        check("to_core_read", core_read, 0);
      end else begin
        check("to_wait", m_error, 0);
      end
      step();
    end
    m_read = '0;
    #1 check("to_idle", busy, 0);
    step();
`endif

    for (int c = 0; c < 3000; c++) begin
      drive_random();
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mrav_bus_arbiter.md
Name: mrav_bus_arbiter

Overview:
- Shares the single core-side port of the mrav bus decoder between N requesters, e.g. instruction fetch, data load/store and a DMA engine.
- Round-robin arbitration. A grant is held for a whole transaction, until the bus returns done.
- Sits between the requesters and the address decoder. Its bus-side ports connect 1:1 to the decoder's core_read/core_write/mrav_* ports.

Parameters:
- N_MASTERS, 2, number of requesters (2..8).
- TIMEOUT_CYCLES, 255, cycles in BUSY before abort. Used only with MRAV_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- m_read  in  N_MASTERS  per-master read request (level, held until done)
- m_write  in  N_MASTERS  per-master write request (level, held until done)
- m_addr  in  N_MASTERS*MRAV_ADDR_WIDTH  packed per-master address, master i at slice i
- m_data_out  in  N_MASTERS*MRAV_DATA_WIDTH  packed per-master write data
- m_data_in  out  MRAV_DATA_WIDTH  read data, shared by all masters
- m_read_done  out  N_MASTERS  per-master read completion
- m_write_done  out  N_MASTERS  per-master write completion
- m_error  out  N_MASTERS  per-master timeout abort pulse (constant 0 without the feature)
- core_read  out  1  to decoder
- core_write  out  1  to decoder
- mrav_addr  out  MRAV_ADDR_WIDTH  to decoder
- mrav_data_out  out  MRAV_DATA_WIDTH  to decoder
- mrav_data_in  in  MRAV_DATA_WIDTH  from decoder
- mrav_read_done  in  1  from decoder
- mrav_write_done  in  1  from decoder
- grant  out  N_MASTERS  one-hot registered grant, 0 when idle
- busy  out  1  high in BUSY

Behaviour:
- Reset: when rst_n=0 at a clk edge, go to IDLE and clear grant. Set last_grant to N_MASTERS-1 so master 0 wins first. Clear the timeout counter. All outputs are 0 from the next cycle.
- Reset mid-transaction: core_read/core_write drop the cycle after reset. No done or error is issued.
- States are IDLE and BUSY.
- IDLE:
  - req[i] = m_read[i] | m_write[i].
  - If any req is set, register the first requesting index scanning last_grant+1, +2, … modulo N_MASTERS.
  - Set grant to that index and go to BUSY. Arbitration latency is 1 cycle.
  - core_read, core_write, mrav_addr, mrav_data_out and all dones are 0 in IDLE.
- BUSY with granted index g:
  - core_read = m_read[g].
  - core_write = m_write[g] & ~m_read[g]. Both set is illegal; it is treated as a read.
  - mrav_addr = m_addr[g]; mrav_data_out = m_data_out[g].
  - m_read_done[g] = mrav_read_done & core_read, combinational. Same rule for write. All other masters' dones are 0.
  - m_data_in = mrav_data_in while BUSY, else 0.
- Completion: on the cycle a done is forwarded, go to IDLE and set last_grant=g. The bus idles for at least 1 cycle between transactions, so the decoder sees request low before the next grant.
- Master abort: if req[g] drops in BUSY with no done, go to IDLE next cycle with no done pulse. last_grant is still updated.
- Requests from non-granted masters are ignored until IDLE. They are never lost while they remain asserted.
- Fairness: a continuously requesting master waits at most N_MASTERS-1 transactions.
- Throughput: one transaction per (bus latency + 1 idle) cycles. A zero-wait peripheral gives 2 cycles per transaction.

Optional Feature:
- Macro MRAV_ARB_TIMEOUT_EN.
- Enabled:
  - A counter clears on entry to BUSY and increments each BUSY cycle.
  - If it reaches TIMEOUT_CYCLES with no done and req still high, pulse m_error[g] for 1 cycle and force core_read/core_write to 0 in that cycle.
  - Then go to IDLE and update last_grant. m_data_in is 0 during the error pulse.
  - The master must drop its request on m_error.
- Disabled: the counter is absent, m_error is tied to 0, and BUSY waits indefinitely.

Test Plan:
- Single read: m_read=01, m_addr[0]=0x100, decoder returns done after 3 cycles with data 0xDEADBEEF. Expect grant=01 1 cycle after the request, m_read_done=01 for 1 cycle, m_data_in=0xDEADBEEF, and grant=00 the next cycle.
- Contention: m_read=11 from reset with zero-wait peripheral. Expect grants 01, 10, 01, 10 on alternating transactions, core_read low for 1 cycle between each, and no done routed to the wrong master.
- Write routing: master 1 writes 0x5A5A to 0x200 while master 0 idles. Expect mrav_addr=0x200, mrav_data_out=0x5A5A, core_write=1, core_read=0, m_write_done=10.
- Abort: master 0 drops m_read 2 cycles into BUSY. Expect IDLE next cycle, no done, and master 1 (pending) granted next.
- Reset mid-transaction: rst_n=0 during BUSY. Expect core_read=0, grant=0 and busy=0 the next cycle. After release, master 0 has priority.
- Timeout (MRAV_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8): the decoder never returns done. Expect m_error[0] high exactly at BUSY cycle 8, core_read low that cycle, and IDLE after.
